clk_timed_pulse_gen: RTL and testbench
======================================

Name: clk_timed_pulse_gen

Overview:
- N-channel, clock-timed pulse generator, parametrised. Successor to the single-channel monoflop.
- Each channel turns a trigger rising edge into a pulse with programmable delay and programmable length.
- Each channel has a selectable mode: level-gated, one-shot or retriggerable.
- Sits between the sequencer's trigger outputs and the TTL/DDS gating lines, and reports busy and lost-trigger status to the host.

Parameters:
- NumChannels, 8, number of independent channels.
- PulseLengthWidth, 16, width of each per-channel pulse-length field.
- DelayWidth, 16, width of each per-channel delay field.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  NumChannels  per-channel arm; gates acceptance of new triggers only.
- trigger  input  NumChannels  per-channel trigger, already synchronous to clk.
- mode  input  2*NumChannels  per-channel mode; channel i uses bits [2i+1:2i].
- delay  input  DelayWidth*NumChannels  per-channel delay in clk cycles; channel i uses slice i.
- pulselength  input  PulseLengthWidth*NumChannels  per-channel pulse length; channel i uses slice i.
- overrun_clear  input  NumChannels  per-channel clear for the overrun flag.
- q  output  NumChannels  pulse outputs, registered.
- busy  output  NumChannels  high while the channel is in DELAY or PULSE, registered.
- overrun  output  NumChannels  sticky lost-trigger flag, registered.

Behaviour:
- Reset: q=0, busy=0, overrun=0, every channel in IDLE, counters 0. The trigger history register resets to all ones, so a trigger held high through reset never fires; it must go low first.
- Edge detection: edge[i] = trigger[i] & ~trig_d[i], where trig_d is trigger registered once.
- Per-channel FSM states: IDLE, DELAY, PULSE. Channels are fully independent; there is no cross-channel interaction.
- IDLE:
  - If edge and enable: latch delay[i] into dcnt and pulselength[i] into pcnt.
  - If latched delay is 0: go to PULSE, q<=1 on that same edge. With delay 0, behaviour is identical to the legacy monoflop.
  - Otherwise go to DELAY.
  - Edge with enable=0: ignored; overrun is not set.
- DELAY:
  - dcnt decrements each cycle.
  - On the edge where dcnt==1: go to PULSE, q<=1.
  - q therefore rises D cycles after the accepting edge.
- PULSE:
  - While pcnt!=0, pcnt decrements. When pcnt==0, q<=0 and go to IDLE.
  - Pulse width is pulselength+1 cycles; pulselength=0 gives a 1-cycle pulse.
- Mode 00, LEVEL:
  - trigger low while in DELAY or PULSE aborts: next edge q<=0, go to IDLE.
  - Re-arming needs a fresh rising edge.
- Mode 01, ONESHOT:
  - trigger level is ignored after acceptance.
  - An edge seen in DELAY or PULSE is dropped and sets overrun.
- Mode 10, RETRIGGER:
  - Edge in PULSE reloads pcnt with the current pulselength[i]; q stays high with no glitch.
  - Edge in DELAY is dropped and sets overrun.
- Mode 11: reserved; behaves as ONESHOT.
- Latching:
  - delay and pulselength are sampled only at acceptance (and at retrigger, for pulselength).
  - Changing them mid-pulse has no effect on the pulse in progress.
  - mode is sampled at acceptance and held until return to IDLE.
- enable falling mid-operation does not abort; the pulse completes.
- busy = (state != IDLE), registered alongside q.
- overrun:
  - Set has priority over overrun_clear in the same cycle.
  - Clearing takes effect on the next edge.
- Reset mid-pulse: q drops on the reset edge; no partial state survives.
- Counter arithmetic: unsigned, no wrap. The counters never decrement below 0.

Optional Feature:
- Macro: CLK_TIMED_PULSE_COUNT_EN.
- With the macro defined:
  - Adds output pulse_count, width 16*NumChannels.
  - Each channel's 16-bit counter increments on every accepted trigger; retriggers do not count.
  - The counter wraps 0xFFFF to 0x0000 and is cleared only by reset.
- Without the macro: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Legacy equivalence: ch0 mode=01, delay=0, pulselength=3, enable=1, trigger rises at edge k -> q[0]=1 after edges k..k+3, q[0]=0 after edge k+4; busy[0] tracks q[0]; overrun=0.
- Delay and abort: ch1 mode=00, delay=5, pulselength=10, trigger high 4 cycles then low -> q[1] never rises, busy[1] drops 1 cycle after trigger falls. Repeat with trigger held 20 cycles -> q[1] high for 11 cycles starting 5 cycles after acceptance.
- Retrigger: ch2 mode=10, delay=0, pulselength=4, second rising edge 3 cycles into the pulse -> q[2] stays high continuously for 3+5=8 cycles; overrun[2]=0. A third edge during a delay=2 phase sets overrun[2]=1.
- Overrun priority: ch3 mode=01, edge in PULSE in the same cycle as overrun_clear[3]=1 -> overrun[3]=1. overrun_clear alone next cycle -> 0.
- Reset and enable: trigger held high through reset release -> no pulse. enable=0 at edge -> no pulse, overrun=0. Reset asserted mid-pulse -> q=0, busy=0 the following cycle.
- Pulse count (CLK_TIMED_PULSE_COUNT_EN defined): 65537 accepted triggers on ch7 -> pulse_count slice 7 = 1; retriggers in mode 10 leave it unchanged.

Source files
------------

// File: rtl/clk_timed_pulse_gen.sv
// N-channel clock-timed pulse generator: rising trigger -> delayed pulse of programmable length.
// Optional per-channel accepted-trigger counters when CLK_TIMED_PULSE_COUNT_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for an enabled rising trigger edge
// S_DELAY | counting down the latched delay, q low
// S_PULSE | q high, counting down the latched pulse length
module clk_timed_pulse_gen #(
   parameter int NumChannels      = 8,
   parameter int PulseLengthWidth = 16,
   parameter int DelayWidth       = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NumChannels-1:0]                 enable,
   input  logic [NumChannels-1:0]                 trigger,
   input  logic [2*NumChannels-1:0]               mode,
   input  logic [DelayWidth*NumChannels-1:0]      delay,
   input  logic [PulseLengthWidth*NumChannels-1:0] pulselength,
   input  logic [NumChannels-1:0]                 overrun_clear,
`ifdef CLK_TIMED_PULSE_COUNT_EN
   output logic [16*NumChannels-1:0]              pulse_count,
`endif
   output logic [NumChannels-1:0]                 q,
   output logic [NumChannels-1:0]                 busy,
   output logic [NumChannels-1:0]                 overrun
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DELAY  = 2'd1;
   localparam logic [1:0] S_PULSE  = 2'd2;
   localparam logic [1:0] M_LEVEL  = 2'b00;
   localparam logic [1:0] M_RETRIG = 2'b10;

   logic [NumChannels-1:0]      r_trig_d;
   logic [1:0]                  r_state [NumChannels];
   logic [1:0]                  r_mode  [NumChannels];
   logic [DelayWidth-1:0]       r_dcnt  [NumChannels];
   logic [PulseLengthWidth-1:0] r_pcnt  [NumChannels];

   logic [NumChannels-1:0]      w_edge;
   logic [NumChannels-1:0]      w_accept;
   logic [NumChannels-1:0]      w_q_nxt;
   logic [NumChannels-1:0]      w_set_ovr;
   logic [NumChannels-1:0]      w_start;
   logic [1:0]                  w_state_nxt [NumChannels];
   logic [1:0]                  w_mode_nxt  [NumChannels];
   logic [DelayWidth-1:0]       w_dcnt_nxt  [NumChannels];
   logic [PulseLengthWidth-1:0] w_pcnt_nxt  [NumChannels];

   assign w_edge   = trigger & ~r_trig_d;
   assign w_accept = w_edge & enable;

   always_comb begin
      for (int i = 0; i < NumChannels; i++) begin
         w_state_nxt[i] = r_state[i];
         w_mode_nxt[i]  = r_mode[i];
         w_dcnt_nxt[i]  = r_dcnt[i];
         w_pcnt_nxt[i]  = r_pcnt[i];
         w_q_nxt[i]     = q[i];
         w_set_ovr[i]   = 1'b0;
         w_start[i]     = 1'b0;
         case (r_state[i])
            S_IDLE: begin
               if (w_accept[i]) begin
                  w_start[i]    = 1'b1;
                  w_mode_nxt[i] = mode[2*i +: 2];
                  w_dcnt_nxt[i] = delay[i*DelayWidth +: DelayWidth];
                  w_pcnt_nxt[i] = pulselength[i*PulseLengthWidth +: PulseLengthWidth];
                  if (delay[i*DelayWidth +: DelayWidth] == '0) begin
                     w_state_nxt[i] = S_PULSE;
                     w_q_nxt[i]     = 1'b1;
                  end else begin
                     w_state_nxt[i] = S_DELAY;
                  end
               end
            end
            S_DELAY: begin
               if (r_mode[i] == M_LEVEL && !trigger[i]) begin
                  w_state_nxt[i] = S_IDLE;
                  w_q_nxt[i]     = 1'b0;
               end else begin
                  w_set_ovr[i] = w_accept[i];
                  if (r_dcnt[i] != '0) w_dcnt_nxt[i] = r_dcnt[i] - DelayWidth'(1);
                  if (r_dcnt[i] <= DelayWidth'(1)) begin
                     w_state_nxt[i] = S_PULSE;
                     w_q_nxt[i]     = 1'b1;
                  end
               end
            end
            S_PULSE: begin
               if (r_mode[i] == M_LEVEL && !trigger[i]) begin
                  w_state_nxt[i] = S_IDLE;
                  w_q_nxt[i]     = 1'b0;
               end else if (w_accept[i] && r_mode[i] == M_RETRIG) begin
                  w_pcnt_nxt[i] = pulselength[i*PulseLengthWidth +: PulseLengthWidth];
               end else begin
                  w_set_ovr[i] = w_accept[i];
                  if (r_pcnt[i] != '0) begin
                     w_pcnt_nxt[i] = r_pcnt[i] - PulseLengthWidth'(1);
                  end else begin
                     w_state_nxt[i] = S_IDLE;
                     w_q_nxt[i]     = 1'b0;
                  end
               end
            end
            default: begin
               w_state_nxt[i] = S_IDLE;
               w_q_nxt[i]     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // All ones so a trigger held high through reset cannot produce an edge.
         r_trig_d <= '1;
         q        <= '0;
         busy     <= '0;
         overrun  <= '0;
         for (int i = 0; i < NumChannels; i++) begin
            r_state[i] <= S_IDLE;
            r_mode[i]  <= '0;
            r_dcnt[i]  <= '0;
            r_pcnt[i]  <= '0;
         end
      end else begin
         r_trig_d <= trigger;
         q        <= w_q_nxt;
         overrun  <= w_set_ovr | (overrun & ~overrun_clear);
         for (int i = 0; i < NumChannels; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_mode[i]  <= w_mode_nxt[i];
            r_dcnt[i]  <= w_dcnt_nxt[i];
            r_pcnt[i]  <= w_pcnt_nxt[i];
            busy[i]    <= (w_state_nxt[i] != S_IDLE);
         end
      end
   end

`ifdef CLK_TIMED_PULSE_COUNT_EN
   logic [15:0] r_pulse_cnt [NumChannels];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NumChannels; i++) r_pulse_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NumChannels; i++) begin
            if (w_start[i]) r_pulse_cnt[i] <= r_pulse_cnt[i] + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < NumChannels; g++) begin : g_cnt
      assign pulse_count[16*g +: 16] = r_pulse_cnt[g];
   end
`else
   logic w_unused;
   assign w_unused = ^w_start;
`endif

endmodule

// File: tb/tb_clk_timed_pulse_gen.sv
// Directed self-checking bench for clk_timed_pulse_gen (default build, 8 channels).
module tb_clk_timed_pulse_gen;
   localparam int NC = 8;
   localparam int PW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [NC-1:0]   enable;
   logic [NC-1:0]   trigger;
   logic [2*NC-1:0] mode;
   logic [DW*NC-1:0] delay;
   logic [PW*NC-1:0] pulselength;
   logic [NC-1:0]   overrun_clear;
   logic [NC-1:0]   q;
   logic [NC-1:0]   busy;
   logic [NC-1:0]   overrun;

   int n_checks = 0;
   int n_errors = 0;

   clk_timed_pulse_gen #(.NumChannels(NC), .PulseLengthWidth(PW), .DelayWidth(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .trigger       (trigger),
      .mode          (mode),
      .delay         (delay),
      .pulselength   (pulselength),
      .overrun_clear (overrun_clear),
      .q             (q),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [1:0] m, input logic [15:0] d, input logic [15:0] l);
      mode[2*ch +: 2]         = m;
      delay[DW*ch +: DW]      = d;
      pulselength[PW*ch +: PW] = l;
   endtask

   initial begin
      reset         = 1'b1;
      enable        = '1;
      trigger       = '0;
      mode          = '0;
      delay         = '0;
      pulselength   = '0;
      overrun_clear = '0;
      set_ch(0, 2'b01, 16'd0, 16'd3);
      set_ch(1, 2'b00, 16'd5, 16'd10);
      set_ch(2, 2'b10, 16'd0, 16'd4);
      set_ch(3, 2'b01, 16'd0, 16'd6);
      set_ch(4, 2'b01, 16'd0, 16'd2);
      set_ch(5, 2'b01, 16'd0, 16'd1);
      set_ch(6, 2'b01, 16'd0, 16'd10);
      set_ch(7, 2'b11, 16'd1, 16'd0);
      trigger[4] = 1'b1;
      repeat (3) tick();
      check("reset_q", q, 0);
      check("reset_busy", busy, 0);
      check("reset_ovr", overrun, 0);

      // trigger held high through reset release never fires
      reset = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("held_trig_q4", q[4], 0);
         check("held_trig_busy4", busy[4], 0);
      end
      trigger[4] = 1'b0;
      tick();

      // legacy monoflop: delay 0, length 3 -> 4 cycles high
      trigger[0] = 1'b1;
      tick();
      pulselength[PW*0 +: PW] = 16'd0;
      for (int j = 0; j < 4; j++) begin
         check("legacy_q0_high", q[0], 1);
         check("legacy_busy0_high", busy[0], 1);
         tick();
      end
      check("legacy_q0_low", q[0], 0);
      check("legacy_busy0_low", busy[0], 0);
      check("legacy_ovr0", overrun[0], 0);
      trigger[0] = 1'b0;
      set_ch(0, 2'b01, 16'd0, 16'd3);

      // level mode abort during delay
      trigger[1] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         check("abort_busy1", busy[1], 1);
         check("abort_q1", q[1], 0);
      end
      trigger[1] = 1'b0;
      tick();
      check("abort_busy1_drop", busy[1], 0);
      for (int j = 0; j < 3; j++) begin
         tick();
         check("abort_q1_never", q[1], 0);
      end

      // level mode held: q high for 11 cycles starting 5 after acceptance
      trigger[1] = 1'b1;
      tick();
      check("lvl_accept_busy1", busy[1], 1);
      check("lvl_accept_q1", q[1], 0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         check("lvl_delay_q1", q[1], 0);
      end
      for (int j = 0; j < 11; j++) begin
         tick();
         check("lvl_pulse_q1", q[1], 1);
      end
      tick();
      check("lvl_end_q1", q[1], 0);
      check("lvl_end_busy1", busy[1], 0);
      trigger[1] = 1'b0;
      tick();

      // retrigger 3 cycles into the pulse -> 8 cycles high
      trigger[2] = 1'b1;
      tick();
      check("rtg_q2_0", q[2], 1);
      trigger[2] = 1'b0;
      tick();
      check("rtg_q2_1", q[2], 1);
      tick();
      check("rtg_q2_2", q[2], 1);
      trigger[2] = 1'b1;
      tick();
      check("rtg_q2_3", q[2], 1);
      trigger[2] = 1'b0;
      for (int j = 4; j < 8; j++) begin
         tick();
         check("rtg_q2_tail", q[2], 1);
      end
      tick();
      check("rtg_q2_end", q[2], 0);
      check("rtg_ovr2", overrun[2], 0);

      // edge during delay phase sets overrun even in retrigger mode
      delay[DW*2 +: DW] = 16'd2;
      trigger[2] = 1'b1;
      tick();
      check("rtg_dly_busy2", busy[2], 1);
      check("rtg_dly_q2", q[2], 0);
      trigger[2] = 1'b0;
      tick();
      check("rtg_dly_ovr2_pre", overrun[2], 0);
      trigger[2] = 1'b1;
      tick();
      check("rtg_dly_ovr2", overrun[2], 1);
      check("rtg_dly_q2_rise", q[2], 1);
      trigger[2] = 1'b0;
      repeat (6) tick();
      check("rtg_dly_q2_done", q[2], 0);
      check("rtg_dly_ovr2_sticky", overrun[2], 1);
      overrun_clear[2] = 1'b1;
      tick();
      overrun_clear[2] = 1'b0;
      check("rtg_ovr2_cleared", overrun[2], 0);

      // overrun set wins over clear in the same cycle
      trigger[3] = 1'b1;
      tick();
      check("ovr_q3", q[3], 1);
      trigger[3] = 1'b0;
      tick();
      trigger[3]       = 1'b1;
      overrun_clear[3] = 1'b1;
      tick();
      check("ovr_priority3", overrun[3], 1);
      check("ovr_q3_kept", q[3], 1);
      trigger[3] = 1'b0;
      tick();
      check("ovr_clear3", overrun[3], 0);
      overrun_clear[3] = 1'b0;
      repeat (4) tick();
      check("ovr_q3_done", q[3], 0);
      check("ovr_busy3_done", busy[3], 0);

      // edge with enable low is ignored, no overrun
      enable[5]  = 1'b0;
      trigger[5] = 1'b1;
      tick();
      check("dis_q5", q[5], 0);
      check("dis_busy5", busy[5], 0);
      check("dis_ovr5", overrun[5], 0);
      trigger[5] = 1'b0;
      enable[5]  = 1'b1;
      tick();

      // delay 1, length 0 in reserved mode 11
      trigger[7] = 1'b1;
      tick();
      check("d1_q7_acc", q[7], 0);
      check("d1_busy7_acc", busy[7], 1);
      trigger[7] = 1'b0;
      tick();
      check("d1_q7_high", q[7], 1);
      tick();
      check("d1_q7_low", q[7], 0);
      check("d1_busy7_low", busy[7], 0);

      // reset mid-pulse
      trigger[6] = 1'b1;
      tick();
      tick();
      check("rst_mid_q6_pre", q[6], 1);
      reset = 1'b1;
      tick();
      check("rst_mid_q6", q[6], 0);
      check("rst_mid_busy6", busy[6], 0);
      reset = 1'b0;
      tick();
      check("rst_mid_q6_after", q[6], 0);
      trigger[6] = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
